mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory stage directly downstream of the execute stage. Consumes ex_to_mem_s and performs data-memory loads/stores
//  over a req/ack bus. Stalls upstream while an access is outstanding, then registers the result into the writeback stage.
//  Supplies the MEM-stage bypass value to execute.
// PARAMETERS
//  ACK_TIMEOUT  255  max cycles waiting for dmem_ack before bus error (>=1)
// PORTS
//  clk          in   1      clock, all state on posedge
//  rst_n        in   1      synchronous active-low reset
//  ex_to_mem    in   struct ex_to_mem_s: alu_result(addr/ALU value), write_data, mem_write, mem_read, reg_write, rd
//  ex_funct3    in   3      access width: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
//  bp_mem       out  32     ex_to_mem.alu_result, combinational (MEM bypass to execute)
//  stall        out  1      upstream must hold ex_to_mem/ex_funct3 stable while high
//  dmem_req     out  1      access request, held until dmem_ack
//  dmem_we      out  1      1 = store
//  dmem_addr    out  32     word-aligned address {alu_result[31:2],2'b00}
//  dmem_wdata   out  32     store data replicated into byte lanes
//  dmem_be      out  4      byte enables
//  dmem_rdata   in   32     load data, valid when dmem_ack
//  dmem_ack     in   1      completes request in same cycle
//  wb_valid     out  1      writeback register holds a retired op
//  wb_reg_write out  1      writeback enable (0 on fault)
//  wb_rd        out  5      destination register
//  wb_data      out  32     ALU result or extended load data (also bp_wb)
//  fault        out  1      1-cycle pulse: misaligned access or ack timeout
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, all registered outputs 0 (wb_*, fault, dmem_req, dmem_we, dmem_be, dmem_addr,
//    dmem_wdata), timeout counter 0. Reset mid-access drops the request. No wb write occurs, and a late ack is ignored.
//  - FSM IDLE/WAIT. dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be are registered.
//  - IDLE, non-memory op (mem_read=mem_write=0): next edge wb_valid=1, wb_data=alu_result, wb_rd=rd,
//    wb_reg_write=reg_write. Latency 1, stall=0.
//  - IDLE, memory op: check alignment (H: addr[0]=0; W: addr[1:0]=0).
//    - Misaligned: no request. Next edge fault=1, wb_valid=1, wb_reg_write=0.
//    - Aligned: stall=1 combinationally. Next edge dmem_req=1 and state=WAIT. mem_write has priority if both flags are set.
//  - Byte enables: B 4'b0001<<addr[1:0]; H 4'b0011<<addr[1:0]; W 4'b1111.
//    Store data: B {4{wd[7:0]}}, H {2{wd[15:0]}}, W wd.
//  - WAIT: stall=1 and wb_valid=0 every cycle. Counter increments each cycle without ack.
//  - WAIT, dmem_ack=1: next edge dmem_req=0, state=IDLE, wb_valid=1, wb_rd=rd, wb_reg_write=reg_write&mem_read.
//    - wb_data for load: lane selected by addr[1:0], sign- or zero-extended per funct3. For store: alu_result.
//    - stall is low in the ack cycle, so upstream advances on that same edge. Total latency for an access is 2 + wait cycles.
//  - WAIT, counter reaches ACK_TIMEOUT-1 without ack: next edge dmem_req=0, state=IDLE, fault=1, wb_valid=1, wb_reg_write=0.
//    Ack and timeout in the same cycle: ack wins.
//  - rd=0: wb_reg_write forced 0.
//  - fault is high for exactly one cycle.
//  - dmem_ack while in IDLE is ignored.
//  - Addresses wrap modulo 2^32. No carry logic.
// TESTING
//  - ADD result 0x0000_1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, stall=0 throughout.
//  - SW addr 0x100, wd 0xDEADBEEF, ack after 3 cycles -> dmem_be=4'hF, dmem_we=1, req held 3 cycles, stall high until ack,
//    wb_reg_write=0.
//  - LB addr 0x203, rdata 0x80FF_FF7F, ack immediate -> wb_data=0xFFFF_FF80.
//    Same test as LBU -> 0x0000_0080.
//  - LH addr 0x101 -> fault pulse, no dmem_req, wb_reg_write=0.
//    SH addr 0x102, wd 0x0000_ABCD -> be=4'b1100, wdata=0xABCD_ABCD.
//  - ACK_TIMEOUT=4, LW with no ack -> req high 4 cycles, then fault=1, stall drops.
//    Ack arriving afterwards is ignored.
//  - rst_n=0 during WAIT -> next edge req=0, all wb_* = 0, state IDLE.
//    Following ADD retires normally.

Source files
------------

// File: rtl/mem_stage_if.sv
// Execute-to-memory payload type and the data-memory req/ack bus used by mem_stage.
// The package sits here so that both the stage and its environment share one definition.
package mem_stage_pkg;
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic        reg_write;
    logic [4:0]  rd;
  } ex_to_mem_s;
endpackage

interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: issues data-memory loads/stores over a req/ack bus, stalls execute while
// an access is outstanding, and registers the retired result for writeback.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  ex_to_mem_s         ex_to_mem,
  input  logic [2:0]         ex_funct3,
  output logic [31:0]        bp_mem,
  output logic               stall,
  mem_stage_if.master        dmem,
  output logic               wb_valid,
  output logic               wb_reg_write,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               fault
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam int unsigned CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d, we_q, we_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          wb_valid_q, wb_valid_d, wb_rwe_q, wb_rwe_d, fault_q, fault_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;

  logic [31:0] addr;
  logic [1:0]  off;
  logic        is_mem, is_load, is_b, is_h, misaligned, wr_en, timeout;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, lane, load_val;

  assign addr       = ex_to_mem.alu_result;
  assign off        = addr[1:0];
  assign is_mem     = ex_to_mem.mem_read | ex_to_mem.mem_write;
  assign is_load    = ex_to_mem.mem_read & ~ex_to_mem.mem_write;
  assign is_b       = (ex_funct3[1:0] == 2'b00);
  assign is_h       = (ex_funct3[1:0] == 2'b01);
  assign misaligned = (is_h & off[0]) | (ex_funct3[1] & (off != 2'b00));
  assign wr_en      = ex_to_mem.reg_write & (ex_to_mem.rd != 5'd0);
  assign timeout    = ~dmem.dmem_ack & (cnt_q == CNT_LAST);

  // Stall releases in the completing cycle (ack or timeout) so upstream advances on the retire edge.
  assign stall  = (state_q == S_IDLE) ? (is_mem & ~misaligned) : ~(dmem.dmem_ack | timeout);
  assign bp_mem = addr;

  always_comb begin
    if (is_b) begin
      be_calc    = 4'b0001 << off;
      wdata_calc = {4{ex_to_mem.write_data[7:0]}};
    end else if (is_h) begin
      be_calc    = 4'b0011 << off;
      wdata_calc = {2{ex_to_mem.write_data[15:0]}};
    end else begin
      be_calc    = 4'b1111;
      wdata_calc = ex_to_mem.write_data;
    end
  end

  always_comb begin
    lane = dmem.dmem_rdata >> {off, 3'b000};
    if (is_b)      load_val = {{24{lane[7]  & ~ex_funct3[2]}}, lane[7:0]};
    else if (is_h) load_val = {{16{lane[15] & ~ex_funct3[2]}}, lane[15:0]};
    else           load_val = lane;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    wb_valid_d = 1'b0;
    wb_rwe_d   = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    fault_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!is_mem || misaligned) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = ex_to_mem.rd;
          wb_data_d  = addr;
          wb_rwe_d   = wr_en & ~is_mem;
          fault_d    = is_mem;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = ex_to_mem.mem_write;
          addr_d  = {addr[31:2], 2'b00};
          wdata_d = wdata_calc;
          be_d    = be_calc;
        end
      end
      default: begin
        if (dmem.dmem_ack || timeout) begin
          state_d    = S_IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = ex_to_mem.rd;
          wb_data_d  = (dmem.dmem_ack && is_load) ? load_val : addr;
          wb_rwe_d   = dmem.dmem_ack & is_load & wr_en;
          fault_d    = ~dmem.dmem_ack;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rwe_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      wb_valid_q <= wb_valid_d;
      wb_rwe_q   <= wb_rwe_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      fault_q    <= fault_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;
  assign wb_valid        = wb_valid_q;
  assign wb_reg_write    = wb_rwe_q;
  assign wb_rd           = wb_rd_q;
  assign wb_data         = wb_data_q;
  assign fault           = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, randomized ops against a
// behavioural model, and hand sequences for reset-in-wait and stray acks.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  ex_to_mem_s  ex;
  logic [2:0]  f3;
  logic [31:0] bp_mem;
  logic        stall, wb_valid, wb_reg_write, fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_stage_if bus();

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_to_mem(ex), .ex_funct3(f3),
    .bp_mem(bp_mem), .stall(stall), .dmem(bus),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, wd;
    logic        mw, mr, rw;
    logic [4:0]  rd;
    logic [2:0]  f3;
    int          delay;
    logic [31:0] rdata;
  } op_t;

  typedef struct {
    logic        fault, rwe, we;
    logic [31:0] data, wdata;
    logic [3:0]  be;
    int          req_cycles;
  } exp_t;

  typedef struct {
    string nm;
    op_t   op;
    exp_t  e;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic op_t mk_op(logic [31:0] alu, logic [31:0] wd, logic mw, logic mr, logic rw,
                                logic [4:0] rd, logic [2:0] fn, int delay, logic [31:0] rdata);
    op_t o;
    o.alu = alu; o.wd = wd; o.mw = mw; o.mr = mr; o.rw = rw;
    o.rd = rd; o.f3 = fn; o.delay = delay; o.rdata = rdata;
    return o;
  endfunction

  function automatic exp_t mk_exp(logic flt, logic rwe, logic [31:0] data, logic [3:0] be,
                                  logic [31:0] wdata, logic we, int reqc);
    exp_t e;
    e.fault = flt; e.rwe = rwe; e.data = data; e.be = be;
    e.wdata = wdata; e.we = we; e.req_cycles = reqc;
    return e;
  endfunction

  // Behavioural reference: access size in bytes, lane arithmetic, ack window of TO cycles.
  function automatic exp_t model(op_t o);
    exp_t e;
    int unsigned sz, off;
    longint unsigned lane, mask;
    e = mk_exp(1'b0, 1'b0, o.alu, 4'h0, 32'h0, 1'b0, 0);
    sz  = o.f3[1] ? 4 : (o.f3[0] ? 2 : 1);
    off = o.alu % 4;
    if (!(o.mr || o.mw)) begin
      e.rwe = o.rw && (o.rd != 0);
      return e;
    end
    if (off % sz != 0) begin
      e.fault = 1'b1;
      return e;
    end
    e.we = o.mw;
    e.be = 4'(((1 << sz) - 1) << off);
    for (int unsigned i = 0; i < 4; i++) e.wdata[8*i +: 8] = o.wd[8*(i % sz) +: 8];
    if (o.delay >= TO) begin
      e.req_cycles = TO;
      e.fault = 1'b1;
      return e;
    end
    e.req_cycles = o.delay + 1;
    if (o.mr && !o.mw) begin
      mask = (64'd1 << (8 * sz)) - 64'd1;
      lane = (64'(o.rdata) >> (8 * off)) & mask;
      if (!o.f3[2] && sz < 4 && lane[8*sz-1]) lane = lane | ~mask;
      e.data = lane[31:0];
      e.rwe  = o.rw && (o.rd != 0);
    end
    return e;
  endfunction

  // Entered 1 time unit after a rising edge; returns 1 time unit after the retire edge.
  task automatic run_op(input string nm, input op_t o, input exp_t e);
    bit last, ack;
    ex.alu_result = o.alu; ex.write_data = o.wd; ex.mem_write = o.mw;
    ex.mem_read = o.mr; ex.reg_write = o.rw; ex.rd = o.rd; f3 = o.f3;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = $urandom;
    @(negedge clk);
    chk({nm, ".bp_mem"}, bp_mem, o.alu);
    chk({nm, ".stall_issue"}, 32'(stall), 32'(e.req_cycles > 0));
    chk({nm, ".req_idle"}, 32'(bus.dmem_req), 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k < e.req_cycles; k++) begin
      last = (k == e.req_cycles - 1);
      ack  = (k == o.delay);
      bus.dmem_ack   = ack;
      bus.dmem_rdata = ack ? o.rdata : $urandom;
      @(negedge clk);
      chk({nm, ".req"}, 32'(bus.dmem_req), 32'd1);
      chk({nm, ".we"}, 32'(bus.dmem_we), 32'(e.we));
      chk({nm, ".addr"}, bus.dmem_addr, {o.alu[31:2], 2'b00});
      chk({nm, ".be"}, 32'(bus.dmem_be), 32'(e.be));
      if (e.we) chk({nm, ".wdata"}, bus.dmem_wdata, e.wdata);
      chk({nm, ".wb_valid_wait"}, 32'(wb_valid), 32'd0);
      chk({nm, ".stall_wait"}, 32'(stall), 32'(!last));
      @(posedge clk); #1;
      bus.dmem_ack = 1'b0;
    end
    chk({nm, ".wb_valid"}, 32'(wb_valid), 32'd1);
    chk({nm, ".fault"}, 32'(fault), 32'(e.fault));
    chk({nm, ".wb_reg_write"}, 32'(wb_reg_write), 32'(e.rwe));
    if (!e.fault) begin
      chk({nm, ".wb_data"}, wb_data, e.data);
      chk({nm, ".wb_rd"}, 32'(wb_rd), 32'(o.rd));
    end
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, ".req"}, 32'(bus.dmem_req), 32'd0);
    chk({nm, ".we"}, 32'(bus.dmem_we), 32'd0);
    chk({nm, ".be"}, 32'(bus.dmem_be), 32'd0);
    chk({nm, ".addr"}, bus.dmem_addr, 32'd0);
    chk({nm, ".wdata"}, bus.dmem_wdata, 32'd0);
    chk({nm, ".wb_valid"}, 32'(wb_valid), 32'd0);
    chk({nm, ".wb_reg_write"}, 32'(wb_reg_write), 32'd0);
    chk({nm, ".wb_rd"}, 32'(wb_rd), 32'd0);
    chk({nm, ".wb_data"}, wb_data, 32'd0);
    chk({nm, ".fault"}, 32'(fault), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[15];
    op_t  o;
    exp_t e;
    int   kind;
    logic [2:0] ld_f3 [5];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    tbl[0]  = '{"add",      mk_op(32'h0000_1234, 32'h0, 0, 0, 1, 5, 3'b000, 0, 32'h0),
                            mk_exp(0, 1, 32'h0000_1234, 4'h0, 32'h0, 0, 0)};
    tbl[1]  = '{"sw_ack3",  mk_op(32'h0000_0100, 32'hDEAD_BEEF, 1, 0, 0, 0, 3'b010, 2, 32'h0),
                            mk_exp(0, 0, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 1, 3)};
    tbl[2]  = '{"lb",       mk_op(32'h0000_0203, 32'h0, 0, 1, 1, 7, 3'b000, 0, 32'h80FF_FF7F),
                            mk_exp(0, 1, 32'hFFFF_FF80, 4'b1000, 32'h0, 0, 1)};
    tbl[3]  = '{"lbu",      mk_op(32'h0000_0203, 32'h0, 0, 1, 1, 7, 3'b100, 0, 32'h80FF_FF7F),
                            mk_exp(0, 1, 32'h0000_0080, 4'b1000, 32'h0, 0, 1)};
    tbl[4]  = '{"lh_mis",   mk_op(32'h0000_0101, 32'h0, 0, 1, 1, 8, 3'b001, 0, 32'h0),
                            mk_exp(1, 0, 32'h0, 4'h0, 32'h0, 0, 0)};
    tbl[5]  = '{"add_aft",  mk_op(32'hFFFF_FFFF, 32'h0, 0, 0, 1, 9, 3'b000, 0, 32'h0),
                            mk_exp(0, 1, 32'hFFFF_FFFF, 4'h0, 32'h0, 0, 0)};
    tbl[6]  = '{"sh",       mk_op(32'h0000_0102, 32'h0000_ABCD, 1, 0, 0, 0, 3'b001, 1, 32'h0),
                            mk_exp(0, 0, 32'h0000_0102, 4'b1100, 32'hABCD_ABCD, 1, 2)};
    tbl[7]  = '{"lw_tmo",   mk_op(32'h0000_0300, 32'h0, 0, 1, 1, 4, 3'b010, 99, 32'h0),
                            mk_exp(1, 0, 32'h0, 4'hF, 32'h0, 0, TO)};
    tbl[8]  = '{"lhu",      mk_op(32'h0000_0202, 32'h0, 0, 1, 1, 10, 3'b101, 0, 32'h8001_1234),
                            mk_exp(0, 1, 32'h0000_8001, 4'b1100, 32'h0, 0, 1)};
    tbl[9]  = '{"lh",       mk_op(32'h0000_0202, 32'h0, 0, 1, 1, 10, 3'b001, 0, 32'h8001_1234),
                            mk_exp(0, 1, 32'hFFFF_8001, 4'b1100, 32'h0, 0, 1)};
    tbl[10] = '{"add_rd0",  mk_op(32'h0000_0042, 32'h0, 0, 0, 1, 0, 3'b000, 0, 32'h0),
                            mk_exp(0, 0, 32'h0000_0042, 4'h0, 32'h0, 0, 0)};
    tbl[11] = '{"sb",       mk_op(32'h0000_0101, 32'h1234_565A, 1, 0, 0, 0, 3'b000, 0, 32'h0),
                            mk_exp(0, 0, 32'h0000_0101, 4'b0010, 32'h5A5A_5A5A, 1, 1)};
    tbl[12] = '{"lw_last",  mk_op(32'h0000_0400, 32'h0, 0, 1, 1, 11, 3'b010, TO-1, 32'hCAFE_F00D),
                            mk_exp(0, 1, 32'hCAFE_F00D, 4'hF, 32'h0, 0, TO)};
    tbl[13] = '{"rw_both",  mk_op(32'h0000_0010, 32'h0BAD_C0DE, 1, 1, 1, 3, 3'b010, 0, 32'h1111_1111),
                            mk_exp(0, 0, 32'h0000_0010, 4'hF, 32'h0BAD_C0DE, 1, 1)};
    tbl[14] = '{"sw_mis",   mk_op(32'h0000_0002, 32'h0, 1, 0, 0, 0, 3'b010, 0, 32'h0),
                            mk_exp(1, 0, 32'h0, 4'h0, 32'h0, 0, 0)};

    rst_n = 1'b0;
    ex = '0;
    f3 = 3'b000;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    chk("reset.stall", 32'(stall), 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_op(tbl[i].nm, tbl[i].op, tbl[i].e);

    // Ack arriving in IDLE right after a timeout must not disturb the next op.
    o = mk_op(32'h0000_0500, 32'h0, 0, 1, 1, 6, 3'b010, 99, 32'h0);
    run_op("tmo2", o, model(o));
    ex.mem_read = 1'b0; ex.rd = 5'd12; ex.alu_result = 32'h0000_7777;
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_ack.stall", 32'(stall), 32'd0);
    chk("late_ack.req", 32'(bus.dmem_req), 32'd0);
    @(posedge clk); #1;
    bus.dmem_ack = 1'b0;
    chk("late_ack.fault", 32'(fault), 32'd0);
    chk("late_ack.wb_valid", 32'(wb_valid), 32'd1);
    chk("late_ack.wb_data", wb_data, 32'h0000_7777);
    chk("late_ack.wb_rd", 32'(wb_rd), 32'd12);

    // Reset while WAIT: request dropped, writeback cleared, late ack ignored afterwards.
    ex.alu_result = 32'h0000_0800; ex.mem_read = 1'b1; ex.mem_write = 1'b0;
    ex.reg_write = 1'b1; ex.rd = 5'd13; f3 = 3'b010;
    @(posedge clk); #1;
    chk("rst_wait.req_before", 32'(bus.dmem_req), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_state("rst_wait");
    rst_n = 1'b1;
    o = mk_op(32'h0000_0099, 32'h0, 0, 0, 1, 14, 3'b000, 0, 32'h0);
    ex.alu_result = o.alu; ex.mem_read = 1'b0; ex.rd = o.rd;
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    chk("rst_wait.stall_after", 32'(stall), 32'd0);
    @(posedge clk); #1;
    bus.dmem_ack = 1'b0;
    chk("rst_wait.add_valid", 32'(wb_valid), 32'd1);
    chk("rst_wait.add_data", wb_data, 32'h0000_0099);
    chk("rst_wait.add_rwe", 32'(wb_reg_write), 32'd1);
    run_op("rst_wait.add2", o, model(o));

    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 3);
      o = mk_op($urandom, $urandom, kind >= 2, kind == 1 || kind == 3, 1'($urandom),
                5'($urandom), 3'b000, $urandom_range(0, 5), $urandom);
      o.f3 = (kind == 1) ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 2) != 0) o.alu[1:0] = o.f3[1] ? 2'b00 : (o.f3[0] ? {o.alu[1], 1'b0} : o.alu[1:0]);
      run_op("rand", o, model(o));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
